// File: rtl/pong_sync_gen.sv
// Pong-style video timing generator: horizontal/vertical counters with
// registered sync, blank and strobe decodes aligned to the counter outputs.
module pong_sync_gen #(
  parameter int H_TOTAL      = 455,
  parameter int H_BLANK_END  = 80,
  parameter int H_SYNC_START = 32,
  parameter int H_SYNC_END   = 64,
  parameter int V_TOTAL      = 262,
  parameter int V_BLANK_END  = 16,
  parameter int V_SYNC_START = 4,
  parameter int V_SYNC_END   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [8:0] hpos,
  output logic [8:0] vpos,
  output logic       h256,
  output logic       v4,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_BE   = 9'(H_BLANK_END);
  localparam logic [8:0] H_SS   = 9'(H_SYNC_START);
  localparam logic [8:0] H_SE   = 9'(H_SYNC_END);
  localparam logic [8:0] V_BE   = 9'(V_BLANK_END);
  localparam logic [8:0] V_SS   = 9'(V_SYNC_START);
  localparam logic [8:0] V_SE   = 9'(V_SYNC_END);

  logic [8:0] h_next;
  logic [8:0] v_next;
  logic       hblank_next;
  logic       vblank_next;

  // Decodes are computed from the next counter values so the registered
  // flags line up with the counters in the same cycle.
  always_comb begin
    h_next = hpos + 9'd1;
    v_next = vpos;
    if (hpos == H_LAST) begin
      h_next = '0;
      v_next = (vpos == V_LAST) ? 9'd0 : vpos + 9'd1;
    end
    hblank_next = (h_next < H_BE);
    vblank_next = (v_next < V_BE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hpos        <= h_next;
      vpos        <= v_next;
      hsync       <= (h_next >= H_SS) && (h_next < H_SE);
      vsync       <= (v_next >= V_SS) && (v_next < V_SE);
      hblank      <= hblank_next;
      vblank      <= vblank_next;
      display_on  <= !hblank_next && !vblank_next;
      line_start  <= (h_next == 9'd0);
      frame_start <= (h_next == 9'd0) && (v_next == 9'd0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  assign h256 = hpos[8];
  assign v4   = vpos[2];

endmodule

// File: tb/tb_pong_sync_gen.sv
// Bench for pong_sync_gen: one default-timing instance and one shrunken
// instance share stimulus; expectations come from a position-count model.
module tb_pong_sync_gen;

  // Shrunken timing so whole frames fit in a short run.
  localparam int S_HT = 20, S_HBE = 6, S_HSS = 2, S_HSE = 4;
  localparam int S_VT = 10, S_VBE = 3, S_VSS = 1, S_VSE = 2;
  localparam int D_HT = 455, D_HBE = 80, D_HSS = 32, D_HSE = 64;
  localparam int D_VT = 262, D_VBE = 16, D_VSS = 4, D_VSE = 8;
  localparam logic [26:0] RESET_VEC =
    {9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset;
  logic ce;

  logic [8:0] d_hpos, d_vpos, s_hpos, s_vpos;
  logic d_h256, d_v4, d_hsync, d_vsync, d_hblank, d_vblank, d_display_on, d_line_start, d_frame_start;
  logic s_h256, s_v4, s_hsync, s_vsync, s_hblank, s_vblank, s_display_on, s_line_start, s_frame_start;

  int errors = 0;
  int checks = 0;

  // Model state: edges counted since reset, and whether the last edge was a ce edge.
  longint n_ticks = 0;
  bit     strobe_ok = 1'b0;

  logic [26:0] obs_d, obs_s, exp_d, exp_s;

  always #5 clk = ~clk;

  pong_sync_gen dut_d (
    .clk(clk), .reset(reset), .ce(ce),
    .hpos(d_hpos), .vpos(d_vpos), .h256(d_h256), .v4(d_v4),
    .hsync(d_hsync), .vsync(d_vsync), .hblank(d_hblank), .vblank(d_vblank),
    .display_on(d_display_on), .line_start(d_line_start), .frame_start(d_frame_start)
  );

  pong_sync_gen #(
    .H_TOTAL(S_HT), .H_BLANK_END(S_HBE), .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE),
    .V_TOTAL(S_VT), .V_BLANK_END(S_VBE), .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE)
  ) dut_s (
    .clk(clk), .reset(reset), .ce(ce),
    .hpos(s_hpos), .vpos(s_vpos), .h256(s_h256), .v4(s_v4),
    .hsync(s_hsync), .vsync(s_vsync), .hblank(s_hblank), .vblank(s_vblank),
    .display_on(s_display_on), .line_start(s_line_start), .frame_start(s_frame_start)
  );

  assign obs_d = {d_hpos, d_vpos, d_h256, d_v4, d_hsync, d_vsync, d_hblank, d_vblank,
                  d_display_on, d_line_start, d_frame_start};
  assign obs_s = {s_hpos, s_vpos, s_h256, s_v4, s_hsync, s_vsync, s_hblank, s_vblank,
                  s_display_on, s_line_start, s_frame_start};

  // Screen position is just the tick count folded by line and frame length.
  function automatic logic [26:0] model(input int ht, input int hbe, input int hss, input int hse,
                                        input int vt, input int vbe, input int vss, input int vse,
                                        input longint n, input bit strobe);
    int h;
    int v;
    logic [8:0] hp;
    logic [8:0] vp;
    bit ls;
    bit fs;
    h  = int'(n % longint'(ht));
    v  = int'((n / longint'(ht)) % longint'(vt));
    hp = 9'(h);
    vp = 9'(v);
    ls = strobe && (h == 0);
    fs = ls && (v == 0);
    return {hp, vp, hp[8], vp[2], (h >= hss) && (h < hse), (v >= vss) && (v < vse),
            h < hbe, v < vbe, (h >= hbe) && (v >= vbe), ls, fs};
  endfunction

  always_comb exp_d = model(D_HT, D_HBE, D_HSS, D_HSE, D_VT, D_VBE, D_VSS, D_VSE, n_ticks, strobe_ok);
  always_comb exp_s = model(S_HT, S_HBE, S_HSS, S_HSE, S_VT, S_VBE, S_VSS, S_VSE, n_ticks, strobe_ok);

  // Drive one clock with the given inputs; returns at the following negedge.
  task automatic cycle(input bit r, input bit c);
    reset = r;
    ce    = c;
    @(posedge clk);
    if (r) begin
      n_ticks   = 0;
      strobe_ok = 1'b0;
    end else if (c) begin
      n_ticks   = n_ticks + 1;
      strobe_ok = 1'b1;
    end else begin
      strobe_ok = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    checks++;
    if (obs_d !== RESET_VEC) begin
      errors++; $display("FAIL reset_default: got %h want %h", obs_d, RESET_VEC);
    end
    checks++;
    if (obs_s !== RESET_VEC) begin
      errors++; $display("FAIL reset_small: got %h want %h", obs_s, RESET_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (obs_d !== RESET_VEC) begin
        errors++; $display("FAIL hold_after_reset: got %h want %h", obs_d, RESET_VEC);
      end
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (d_hpos !== 9'd1 || d_vpos !== 9'd0 || d_line_start !== 1'b0) begin
      errors++; $display("FAIL first_ce_edge: got h=%0d v=%0d ls=%b want h=1 v=0 ls=0",
                         d_hpos, d_vpos, d_line_start);
    end
  endtask

  task automatic test_line_sweep;
    int n_hsync = 0, n_hblank = 0, n_h256 = 0, n_ls = 0, n_fs = 0;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < D_HT; i++) begin
      checks++;
      if (obs_d !== exp_d) begin
        errors++; $display("FAIL line_sweep_d n=%0d: got %h want %h", n_ticks, obs_d, exp_d);
      end
      checks++;
      if (obs_s !== exp_s) begin
        errors++; $display("FAIL line_sweep_s n=%0d: got %h want %h", n_ticks, obs_s, exp_s);
      end
      n_hsync += int'(d_hsync); n_hblank += int'(d_hblank); n_h256 += int'(d_h256);
      n_ls += int'(d_line_start); n_fs += int'(d_frame_start);
      cycle(1'b0, 1'b1);
    end
    n_ls += int'(d_line_start); n_fs += int'(d_frame_start);
    checks++;
    if (d_hpos !== 9'd0 || d_vpos !== 9'd1) begin
      errors++; $display("FAIL line_wrap: got h=%0d v=%0d want h=0 v=1", d_hpos, d_vpos);
    end
    checks++;
    if (n_hsync != 32 || n_hblank != 80 || n_h256 != 199) begin
      errors++; $display("FAIL line_counts: got hsync=%0d hblank=%0d h256=%0d want 32 80 199",
                         n_hsync, n_hblank, n_h256);
    end
    checks++;
    if (n_ls != 1 || n_fs != 0) begin
      errors++; $display("FAIL line_strobes: got ls=%0d fs=%0d want 1 0", n_ls, n_fs);
    end
  endtask

  task automatic test_frame_sweep;
    int d_vs = 0, d_vb = 0, d_v4c = 0;
    int s_vs = 0, s_vb = 0, s_disp = 0, s_ls = 0, s_fs = 0;
    int lines = 20;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < lines * D_HT; i++) begin
      checks++;
      if (obs_d !== exp_d) begin
        errors++; $display("FAIL frame_sweep_d n=%0d: got %h want %h", n_ticks, obs_d, exp_d);
      end
      checks++;
      if (obs_s !== exp_s) begin
        errors++; $display("FAIL frame_sweep_s n=%0d: got %h want %h", n_ticks, obs_s, exp_s);
      end
      d_vs += int'(d_vsync); d_vb += int'(d_vblank); d_v4c += int'(d_v4);
      if (i < S_HT * S_VT) begin
        s_vs += int'(s_vsync); s_vb += int'(s_vblank); s_disp += int'(s_display_on);
      end
      if (i >= 1 && i <= S_HT * S_VT) begin
        s_ls += int'(s_line_start); s_fs += int'(s_frame_start);
      end
      cycle(1'b0, 1'b1);
    end
    checks++;
    if (d_vs != 4 * D_HT || d_vb != 16 * D_HT || d_v4c != 8 * D_HT) begin
      errors++; $display("FAIL default_v_counts: got vs=%0d vb=%0d v4=%0d want %0d %0d %0d",
                         d_vs, d_vb, d_v4c, 4 * D_HT, 16 * D_HT, 8 * D_HT);
    end
    checks++;
    if (s_vs != 20 || s_vb != 60 || s_disp != 98) begin
      errors++; $display("FAIL small_frame_counts: got vs=%0d vb=%0d disp=%0d want 20 60 98",
                         s_vs, s_vb, s_disp);
    end
    checks++;
    if (s_ls != S_VT || s_fs != 1) begin
      errors++; $display("FAIL small_frame_strobes: got ls=%0d fs=%0d want %0d 1", s_ls, s_fs, S_VT);
    end
  endtask

  task automatic test_random_ce;
    int pulses = 0, n_ls = 0, n_fs = 0;
    bit c;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      c = ($urandom_range(0, 3) != 0);
      cycle(1'b0, c);
      pulses += int'(c);
      n_ls += int'(s_line_start); n_fs += int'(s_frame_start);
      checks++;
      if (obs_s !== exp_s) begin
        errors++; $display("FAIL random_ce_s n=%0d: got %h want %h", n_ticks, obs_s, exp_s);
      end
      checks++;
      if (obs_d !== exp_d) begin
        errors++; $display("FAIL random_ce_d n=%0d: got %h want %h", n_ticks, obs_d, exp_d);
      end
    end
    checks++;
    if (n_fs != pulses / (S_HT * S_VT) || n_ls != pulses / S_HT) begin
      errors++; $display("FAIL random_ce_strobes: got fs=%0d ls=%0d want %0d %0d",
                         n_fs, n_ls, pulses / (S_HT * S_VT), pulses / S_HT);
    end
  endtask

  task automatic test_reset_mid_frame;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 100 * D_HT + 200; i++) begin
      cycle(1'b0, 1'b1);
      checks++;
      if (obs_d !== exp_d) begin
        errors++; $display("FAIL run_to_mid n=%0d: got %h want %h", n_ticks, obs_d, exp_d);
      end
    end
    checks++;
    if (d_hpos !== 9'd200 || d_vpos !== 9'd100) begin
      errors++; $display("FAIL mid_position: got h=%0d v=%0d want 200 100", d_hpos, d_vpos);
    end
    cycle(1'b1, 1'b1);
    checks++;
    if (obs_d !== RESET_VEC) begin
      errors++; $display("FAIL mid_frame_reset: got %h want %h", obs_d, RESET_VEC);
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (d_hpos !== 9'd1 || d_vpos !== 9'd0 || d_hblank !== 1'b1) begin
      errors++; $display("FAIL restart_after_mid_reset: got h=%0d v=%0d hb=%b want 1 0 1",
                         d_hpos, d_vpos, d_hblank);
    end
  endtask

  // Reset arriving on the very edge that would wrap the frame must not leak a strobe.
  task automatic test_reset_at_wrap;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < S_HT * S_VT - 1; i++) cycle(1'b0, 1'b1);
    checks++;
    if (s_hpos !== 9'(S_HT - 1) || s_vpos !== 9'(S_VT - 1)) begin
      errors++; $display("FAIL at_last_pos: got h=%0d v=%0d want %0d %0d",
                         s_hpos, s_vpos, S_HT - 1, S_VT - 1);
    end
    cycle(1'b1, 1'b1);
    checks++;
    if (obs_s !== RESET_VEC) begin
      errors++; $display("FAIL reset_at_wrap: got %h want %h", obs_s, RESET_VEC);
    end
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, $urandom_range(0, 1) == 1);
      checks++;
      if (obs_s !== exp_s) begin
        errors++; $display("FAIL after_wrap_reset n=%0d: got %h want %h", n_ticks, obs_s, exp_s);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ce    = 1'b0;
    @(negedge clk);
    test_reset();
    test_line_sweep();
    test_frame_sweep();
    test_random_ce();
    test_reset_mid_frame();
    test_reset_at_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_sync_gen.md
PONG_SYNC_GEN -- requirements
Module: pong_sync_gen

Interface
REQ-001 SHALL have parameter H_TOTAL, default 455, horizontal counts per line.
REQ-002 SHALL have parameter H_BLANK_END, default 80, first visible horizontal count.
REQ-003 SHALL have parameter H_SYNC_START, default 32, first hsync count.
REQ-004 SHALL have parameter H_SYNC_END, default 64, first count after hsync.
REQ-005 SHALL have parameter V_TOTAL, default 262, lines per frame.
REQ-006 SHALL have parameter V_BLANK_END, default 16, first visible line.
REQ-007 SHALL have parameter V_SYNC_START, default 4, first vsync line.
REQ-008 SHALL have parameter V_SYNC_END, default 8, first line after vsync.
REQ-009 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-010 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-011 SHALL have port ce, input, 1, pixel-count enable.
REQ-012 SHALL have port hpos, output, 9, horizontal count.
REQ-013 SHALL have port vpos, output, 9, line count.
REQ-014 SHALL have port h256, output, 1, hpos bit 8 (net/centre timing).
REQ-015 SHALL have port v4, output, 1, vpos bit 2 (net dash timing).
REQ-016 SHALL have ports hsync, vsync, hblank, vblank, display_on, output, 1 each, active-high.
REQ-017 SHALL have ports line_start, frame_start, output, 1 each, single-cycle strobes.

Function
REQ-018 SHALL advance hpos by 1 on each clk edge with ce=1; ce=0 SHALL hold every output except the strobes, which SHALL be 0.
REQ-019 SHALL wrap hpos from H_TOTAL-1 to 0 and, in the same edge, increment vpos.
REQ-020 SHALL wrap vpos from V_TOTAL-1 to 0 when hpos wraps on the last line; simultaneous wraps SHALL give hpos=0, vpos=0.
REQ-021 SHALL register every decoded output so that it is consistent with the hpos/vpos value presented in the same cycle (zero relative latency).
REQ-022 SHALL drive h256=hpos[8], v4=vpos[2].
REQ-023 SHALL assert hblank when hpos<H_BLANK_END; vblank when vpos<V_BLANK_END.
REQ-024 SHALL assert hsync when H_SYNC_START<=hpos<H_SYNC_END; vsync when V_SYNC_START<=vpos<V_SYNC_END.
REQ-025 SHALL assert display_on = !hblank & !vblank.
REQ-026 SHALL pulse line_start for exactly one clk in the cycle following the ce edge that loads hpos=0.
REQ-027 SHALL pulse frame_start for exactly one clk in the cycle following the ce edge that loads hpos=0, vpos=0; line_start SHALL pulse in the same cycle.
REQ-028 SHALL treat parameters with H_SYNC_END>H_BLANK_END, V_SYNC_END>V_BLANK_END, or H_TOTAL/V_TOTAL>512 as illegal; behaviour is undefined.

Reset
REQ-029 SHALL, on clk edge with reset=1 (regardless of ce), load hpos=0, vpos=0, h256=0, v4=0, hsync=0, vsync=0, hblank=1, vblank=1, display_on=0, line_start=0, frame_start=0.
REQ-030 SHALL, after reset deasserts, count from hpos=0, vpos=0 on the first ce=1 edge (next value hpos=1); no frame_start strobe for the reset itself.
REQ-031 SHALL give reset priority over ce; reset mid-frame SHALL abort the frame with no residual strobe.

Verification
REQ-032 Reset, then ce=1 continuously for 455 clks -> hpos 0..454 then 0, vpos 0->1, one line_start, no frame_start.
REQ-033 ce=1 for 455*262=119210 clks after reset -> exactly one frame_start, at vpos=0/hpos=0 wrap; 262 line_start pulses.
REQ-034 Sweep one line -> hsync high for hpos 32..63 (32 counts), hblank high 0..79, h256 high 256..454 (199 counts).
REQ-035 Sweep one frame -> vsync high lines 4..7, vblank lines 0..15, v4 toggles every 4 lines, display_on 375*246 counts total.
REQ-036 ce toggled 1/0 pseudo-randomly -> counters advance only on ce=1, strobes only on ce=1 wrap edges, one frame per 119210 ce pulses.
REQ-037 reset asserted at hpos=200, vpos=100 with ce=1 -> next cycle all outputs at REQ-029 values; counting restarts cleanly.
